tile_pack_sequencer: RTL and testbench

Sequencer that owns the single shared address/control port of the asymmetric write RAM (`asymmertic_wr_ram`: narrow write, wide read) in the matrix-multiplication datapath. It first packs a tile of narrow input words into the RAM, one narrow word per cycle. It then drains the tile as wide rows to the compute array over a valid/ready stream. A 2-entry output buffer with credit-based read issue absorbs the RAM's 1-cycle read latency and downstream backpressure.

---
 rtl/tile_pack_sequencer.sv | 160 ++++++++++++++++
 tb/tb_tile_pack_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_pack_sequencer.sv
// Packs a tile of narrow words into the asymmetric RAM, then drains it as wide rows
// through a 2-entry buffer that hides the RAM's 1-cycle read latency.
module tile_pack_sequencer #(
  parameter int unsigned DATA_RATIO = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TILE_ROWS  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             tile_done,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             mem_if_write,
  output logic [ADDR_WIDTH-1:0]            mem_if_address,
  output logic [DATA_WIDTH-1:0]            mem_if_write_data,
  output logic [DATA_WIDTH/8-1:0]          mem_if_write_strb,
  input  logic [DATA_RATIO*DATA_WIDTH-1:0] mem_if_read_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_RATIO*DATA_WIDTH-1:0] out_data,
  output logic                             out_last
);

  localparam int unsigned NumWords  = TILE_ROWS * DATA_RATIO;
  localparam int unsigned RowWidth  = DATA_RATIO * DATA_WIDTH;
  localparam int unsigned WordBytes = DATA_WIDTH / 8;
  localparam int unsigned RowBytes  = DATA_RATIO * WordBytes;
  localparam int unsigned KW        = $clog2(NumWords + 1);
  localparam int unsigned RW        = $clog2(TILE_ROWS + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e              state_q;
  logic [KW-1:0]       k_q;
  logic [RW-1:0]       r_q;
  logic [RowWidth-1:0] buf_q [2];
  logic [1:0]          last_q;
  logic [1:0]          occ_q;
  logic                inflight_q;
  logic                inflight_last_q;
  logic                tile_done_q;

  logic       in_hs;
  logic       last_word;
  logic       rows_left;
  logic       pop;
  logic       push;
  logic       rd_issue;
  logic [2:0] credit;

  assign busy      = (state_q != StIdle);
  assign in_ready  = (state_q == StLoad);
  assign tile_done = tile_done_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf_q[0];
  assign out_last  = out_valid & last_q[0];

  always_comb begin
    in_hs     = (state_q == StLoad) & in_valid;
    last_word = (k_q == KW'(NumWords - 1));
    rows_left = (r_q < RW'(TILE_ROWS));
    pop       = out_valid & out_ready;
    push      = inflight_q;
    // Buffered plus in-flight rows, net of this cycle's pop, must leave room for one more.
    credit    = 3'(occ_q) + 3'(inflight_q);
    rd_issue  = (state_q == StDrain) & rows_left & (credit < (3'd2 + 3'(pop)));

    mem_if_write      = in_hs;
    mem_if_write_data = in_data;
    mem_if_write_strb = {WordBytes{in_hs}};
    if (in_hs) begin
      mem_if_address = ADDR_WIDTH'(k_q) * ADDR_WIDTH'(WordBytes);
    end else if (rd_issue) begin
      mem_if_address = ADDR_WIDTH'(r_q) * ADDR_WIDTH'(RowBytes);
    end else begin
      mem_if_address = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      k_q             <= '0;
      r_q             <= '0;
      buf_q[0]        <= '0;
      buf_q[1]        <= '0;
      last_q          <= '0;
      occ_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      tile_done_q     <= 1'b0;
    end else begin
      tile_done_q <= 1'b0;
      inflight_q  <= rd_issue;
      if (rd_issue) begin
        inflight_last_q <= (r_q == RW'(TILE_ROWS - 1));
        r_q             <= r_q + RW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            k_q     <= '0;
            r_q     <= '0;
          end
        end
        StLoad: begin
          if (in_hs) begin
            k_q <= k_q + KW'(1);
            if (last_word) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && out_last) begin
            state_q     <= StIdle;
            tile_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Head-at-index-0 FIFO; read data lands the cycle after issue.
      unique case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            buf_q[0]  <= mem_if_read_data;
            last_q[0] <= inflight_last_q;
          end else begin
            buf_q[1]  <= mem_if_read_data;
            last_q[1] <= inflight_last_q;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          buf_q[0]  <= buf_q[1];
          last_q[0] <= last_q[1];
          occ_q     <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf_q[0]  <= mem_if_read_data;
            last_q[0] <= inflight_last_q;
          end else begin
            buf_q[0]  <= buf_q[1];
            last_q[0] <= last_q[1];
            buf_q[1]  <= mem_if_read_data;
            last_q[1] <= inflight_last_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_pack_sequencer.sv
// Bench for tile_pack_sequencer: RAM model, tile-level reference model checked every
// cycle, and directed scenarios with hand-computed literal expectations.
module tb_tile_pack_sequencer;

  localparam int unsigned DR  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned TR  = 4;
  localparam int unsigned NW  = TR * DR;
  localparam int unsigned RWD = DR * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            tile_done;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            mem_if_write;
  logic [AW-1:0]   mem_if_address;
  logic [DW-1:0]   mem_if_write_data;
  logic [DW/8-1:0] mem_if_write_strb;
  logic [RWD-1:0]  mem_if_read_data;
  logic            out_valid;
  logic            out_ready;
  logic [RWD-1:0]  out_data;
  logic            out_last;

  always #5 clk = ~clk;

  tile_pack_sequencer #(
    .DATA_RATIO(DR),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TILE_ROWS (TR)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .busy             (busy),
    .tile_done        (tile_done),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .mem_if_write     (mem_if_write),
    .mem_if_address   (mem_if_address),
    .mem_if_write_data(mem_if_write_data),
    .mem_if_write_strb(mem_if_write_strb),
    .mem_if_read_data (mem_if_read_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last)
  );

  // Narrow-write / wide-read RAM with one cycle of read latency.
  logic [DW-1:0] ram [NW];
  always @(posedge clk) begin
    if (mem_if_write) ram[mem_if_address[5:2]] <= mem_if_write_data;
    mem_if_read_data <= {ram[{mem_if_address[5:4], 2'd3}], ram[{mem_if_address[5:4], 2'd2}],
                         ram[{mem_if_address[5:4], 2'd1}], ram[{mem_if_address[5:4], 2'd0}]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model state: phase 0 idle, 1 load, 2 drain.
  int            m_phase = 0;
  int            m_k = 0;
  int            m_rows = 0;
  int            m_next_rd = 1;
  int            m_dc = 0;
  bit            m_done = 1'b0;
  bit            m_no_stall = 1'b0;
  bit            m_prev_stall = 1'b0;
  logic [DW-1:0] words[$];
  logic [RWD-1:0] got_rows[$];
  int            wr_addrs[$];
  int            rd_addrs[$];
  int            last_wr_cyc = -1;
  int            first_valid_cyc = -1;
  int            done_cyc = -1;
  logic          hs;

  function automatic logic [RWD-1:0] exp_row(input int r);
    logic [RWD-1:0] row;
    row = '0;
    for (int j = 0; j < DR; j++) row[DW*j +: DW] = words[DR*r + j];
    return row;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      hs = out_valid & out_ready;
      check("busy", busy, m_phase != 0);
      check("in_ready", in_ready, m_phase == 1);
      check("tile_done", tile_done, m_done);
      check("wr_en", mem_if_write, (m_phase == 1) && in_valid);
      if (m_phase == 1 && in_valid) begin
        check("wr_addr", mem_if_address, m_k * 4);
        check("wr_strb", mem_if_write_strb, 4'hF);
        check("wr_data", mem_if_write_data, in_data);
        wr_addrs.push_back(int'(mem_if_address));
        if (m_k == NW - 1) last_wr_cyc = cyc;
      end else begin
        check("strb_idle", mem_if_write_strb, 0);
      end
      if (m_phase == 0 || (m_phase == 1 && !in_valid)) check("addr_idle", mem_if_address, 0);
      if (m_phase != 2) begin
        check("out_valid_idle", out_valid, 0);
        check("out_last_idle", out_last, 0);
      end else begin
        if (mem_if_address != 0) begin
          check("rd_addr", mem_if_address, (m_next_rd < TR) ? m_next_rd * 16 : 0);
          rd_addrs.push_back(int'(mem_if_address));
          m_next_rd++;
        end
        if (m_no_stall) check("out_valid_lat", out_valid, m_dc >= 2);
        if (m_prev_stall) check("out_hold", out_valid, 1);
        if (out_valid) begin
          check("out_data", out_data, exp_row(m_rows));
          check("out_last", out_last, m_rows == TR - 1);
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end else begin
          check("out_last_nv", out_last, 0);
        end
        if (hs) got_rows.push_back(out_data);
      end
      if (tile_done) done_cyc = cyc;

      if (rst) begin
        m_phase      = 0;
        m_done       = 1'b0;
        m_prev_stall = 1'b0;
      end else begin
        m_done       = (m_phase == 2) && hs && (m_rows == TR - 1);
        m_prev_stall = (m_phase == 2) && out_valid && !out_ready;
        case (m_phase)
          0: if (start) begin
            m_phase = 1;
            m_k     = 0;
            words.delete();
            got_rows.delete();
            wr_addrs.delete();
            rd_addrs.delete();
            last_wr_cyc     = -1;
            first_valid_cyc = -1;
            done_cyc        = -1;
          end
          1: if (in_valid) begin
            words.push_back(in_data);
            m_k++;
            if (m_k == NW) begin
              m_phase    = 2;
              m_dc       = 0;
              m_rows     = 0;
              m_next_rd  = 1;
              m_no_stall = 1'b1;
            end
          end
          default: begin
            if (!out_ready) m_no_stall = 1'b0;
            m_dc++;
            if (hs) begin
              m_rows++;
              if (m_rows == TR) m_phase = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_entry", in_ready, 1);
  endtask

  task automatic load_words(input int base, input bit gap, input bit start_glitch);
    for (int i = 0; i < NW; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + i);
      if (start_glitch && i == 5) start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      if (gap && i != NW - 1) tick();
    end
    check("drain_busy", busy, 1);
    check("drain_entry", in_ready, 0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (tile_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", tile_done, 1);
    tick();
  endtask

  initial begin
    int n16;
    int nbig;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick();
    tick();
    cmp_en = 1'b1;
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_addr", mem_if_address, 0);
    check("rst_strb", mem_if_write_strb, 0);
    check("rst_wr", mem_if_write, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_beats_start", busy, 0);
    rst = 1'b0;
    tick();

    // Basic tile with latency pins.
    start_tile();
    load_words(0, 1'b0, 1'b0);
    wait_done(40);
    check("t1_nrows", got_rows.size(), 4);
    check("t1_row0", got_rows[0], 128'h00000003_00000002_00000001_00000000);
    check("t1_row3", got_rows[3], 128'h0000000F_0000000E_0000000D_0000000C);
    check("t1_wr1", wr_addrs[1], 4);
    check("t1_wr15", wr_addrs[15], 60);
    check("t1_nrd", rd_addrs.size(), 3);
    check("t1_rd1", rd_addrs[0], 16);
    check("t1_rd3", rd_addrs[2], 48);
    check("t1_first_valid", first_valid_cyc - last_wr_cyc, 3);
    check("t1_done_lat", done_cyc - last_wr_cyc, 7);

    // Input gaps.
    start_tile();
    load_words(32'h20, 1'b1, 1'b0);
    wait_done(40);
    check("t2_nwr", wr_addrs.size(), 16);
    check("t2_row2", got_rows[2], 128'h0000002B_0000002A_00000029_00000028);
    check("t2_done_lat", done_cyc - last_wr_cyc, 7);

    // Backpressure after DRAIN entry.
    out_ready = 1'b0;
    start_tile();
    load_words(32'h40, 1'b0, 1'b0);
    n16 = 0;
    nbig = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_if_address == 16) n16++;
      if (mem_if_address > 16) nbig++;
      tick();
    end
    check("t3_rd_row1", n16, 1);
    check("t3_rd_more", nbig, 0);
    check("t3_valid", out_valid, 1);
    check("t3_head", out_data, 128'h00000043_00000042_00000041_00000040);
    out_ready = 1'b1;
    wait_done(40);
    check("t3_nrows", got_rows.size(), 4);
    check("t3_row1", got_rows[1], 128'h00000047_00000046_00000045_00000044);
    check("t3_row3", got_rows[3], 128'h0000004F_0000004E_0000004D_0000004C);

    // start pulses while busy.
    start_tile();
    load_words(32'h60, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40);
    check("t4_nwr", wr_addrs.size(), 16);
    check("t4_nrows", got_rows.size(), 4);
    check("t4_row0", got_rows[0], 128'h00000063_00000062_00000061_00000060);
    check("t4_idle", busy, 0);

    // Reset with one row buffered and one in flight.
    out_ready = 1'b0;
    start_tile();
    load_words(32'h80, 1'b0, 1'b0);
    tick();
    tick();
    check("t5_pre_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    check("t5_busy", busy, 0);
    check("t5_valid", out_valid, 0);
    check("t5_data", out_data, 0);
    check("t5_last", out_last, 0);
    check("t5_addr", mem_if_address, 0);
    check("t5_strb", mem_if_write_strb, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_done", tile_done, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    start_tile();
    load_words(32'hA0, 1'b0, 1'b0);
    wait_done(40);
    check("t5_nrows", got_rows.size(), 4);
    check("t5_row0", got_rows[0], 128'h000000A3_000000A2_000000A1_000000A0);
    check("t5_row3", got_rows[3], 128'h000000AF_000000AE_000000AD_000000AC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
